// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and helpers for the slice comparator cascade
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } cmp_cas_state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  typedef struct packed {
    logic decided;
    logic lt;
    logic gt;
  } cmp_fold_t;

  function automatic logic is_onehot3(input cmp_flags_t f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

endpackage

// File: rtl/cmp_slice_cascade_if.sv
// rtl/cmp_slice_cascade_if.sv - slice-in / result-out handshake bundle for the cascade
interface cmp_slice_cascade_if #(
  parameter int MAX_SLICES = 8
);
  localparam int CW = $clog2(MAX_SLICES + 1);

  logic          s_valid;
  logic          s_ready;
  logic          s_lt;
  logic          s_eq;
  logic          s_gt;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic          m_lt;
  logic          m_eq;
  logic          m_gt;
  logic [CW-1:0] m_nslices;
  logic          err_onehot;
  logic          err_overrun;

  modport master (
    output s_valid, s_lt, s_eq, s_gt, s_last, m_ready,
    input  s_ready, m_valid, m_lt, m_eq, m_gt, m_nslices, err_onehot, err_overrun
  );

  modport slave (
    input  s_valid, s_lt, s_eq, s_gt, s_last, m_ready,
    output s_ready, m_valid, m_lt, m_eq, m_gt, m_nslices, err_onehot, err_overrun
  );

endinterface

// File: rtl/cmp_slice_merge.sv
// rtl/cmp_slice_merge.sv - folds one MSB-first slice into the running magnitude decision
module cmp_slice_merge
  import cmp_pkg::*;
(
  input  cmp_fold_t  fold_in,
  input  cmp_flags_t slice,
  output cmp_fold_t  fold_out
);

  // A malformed slice is treated as equal, so it can never decide.
  always_comb begin
    fold_out = fold_in;
    if (!fold_in.decided && is_onehot3(slice) && !slice.eq) begin
      fold_out.decided = 1'b1;
      fold_out.lt      = slice.lt;
      fold_out.gt      = slice.gt;
    end
  end

endmodule

// File: rtl/cmp_slice_cascade.sv
// rtl/cmp_slice_cascade.sv - folds streamed 2-bit slice compare flags into one wide result
module cmp_slice_cascade #(
  parameter int MAX_SLICES = 8
) (
  input logic                clk,
  input logic                rst_n,
  cmp_slice_cascade_if.slave bus
);
  import cmp_pkg::*;

  localparam int            CW      = $clog2(MAX_SLICES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SLICES);

  cmp_cas_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  cmp_fold_t      fold_q, fold_d, fold_merged;
  cmp_flags_t     slice_flags;
  cmp_flags_t     m_flags_q, m_flags_d;
  logic [CW-1:0]  m_nslices_q, m_nslices_d;
  logic           m_valid_q, m_valid_d;
  logic           err_onehot_q, err_onehot_d;
  logic           err_overrun_q, err_overrun_d;
  logic           accept;

  assign bus.s_ready = (state_q != HOLD);
  assign accept      = bus.s_valid && (state_q != HOLD);
  assign slice_flags = '{lt: bus.s_lt, eq: bus.s_eq, gt: bus.s_gt};
  assign cnt_inc     = cnt_q + CW'(1);

  cmp_slice_merge u_merge (
    .fold_in  (fold_q),
    .slice    (slice_flags),
    .fold_out (fold_merged)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fold_d        = fold_q;
    m_valid_d     = m_valid_q;
    m_flags_d     = m_flags_q;
    m_nslices_d   = m_nslices_q;
    err_onehot_d  = accept && !is_onehot3(slice_flags);
    err_overrun_d = 1'b0;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          cnt_d  = cnt_inc;
          fold_d = fold_merged;
          // Close on the LSB slice, or force-close once the counter is full.
          if (bus.s_last || (cnt_inc == MAX_CNT)) begin
            state_d       = HOLD;
            m_valid_d     = 1'b1;
            m_flags_d     = '{lt: fold_merged.lt, eq: !fold_merged.decided, gt: fold_merged.gt};
            m_nslices_d   = cnt_inc;
            err_overrun_d = !bus.s_last;
          end else begin
            state_d = ACC;
          end
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          state_d     = IDLE;
          cnt_d       = '0;
          fold_d      = '0;
          m_valid_d   = 1'b0;
          m_flags_d   = '0;
          m_nslices_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      fold_q        <= '0;
      m_valid_q     <= 1'b0;
      m_flags_q     <= '0;
      m_nslices_q   <= '0;
      err_onehot_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fold_q        <= fold_d;
      m_valid_q     <= m_valid_d;
      m_flags_q     <= m_flags_d;
      m_nslices_q   <= m_nslices_d;
      err_onehot_q  <= err_onehot_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign bus.m_valid     = m_valid_q;
  assign bus.m_lt        = m_flags_q.lt;
  assign bus.m_eq        = m_flags_q.eq;
  assign bus.m_gt        = m_flags_q.gt;
  assign bus.m_nslices   = m_nslices_q;
  assign bus.err_onehot  = err_onehot_q;
  assign bus.err_overrun = err_overrun_q;

endmodule
